// File: rtl/vip_stream_packetizer.sv
// ==========================================================================
// vip_stream_packetizer: raw pixel stream -> Avalon-ST Video (control + video packets).
// Optional control packet build macro: PKTZ_CTRL_PACKET_EN.  Rev 1.0
// ==========================================================================
`default_nettype none

module vip_stream_packetizer #(
  parameter int unsigned FRAME_W = 640,
  parameter int unsigned FRAME_H = 480,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [11:0] pix_data,
  input  logic        pix_valid,
  input  logic        pix_sof,
  output logic [11:0] dout_data,
  output logic        dout_valid,
  output logic        dout_startofpacket,
  output logic        dout_endofpacket,
  input  logic        dout_ready,
  output logic        overflow,
  output logic [15:0] frame_count
);

  localparam int unsigned    DEPTH    = 1 << FIFO_AW;
  localparam logic [31:0]    LAST_IDX = 32'(FRAME_W) * 32'(FRAME_H) - 32'd1;
  localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

`ifdef PKTZ_CTRL_PACKET_EN
  localparam logic [15:0] W16 = 16'(FRAME_W);
  localparam logic [15:0] H16 = 16'(FRAME_H);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CTRL_HDR = 3'd1,
    CTRL_B1  = 3'd2,
    CTRL_B2  = 3'd3,
    CTRL_B3  = 3'd4,
    VID_HDR  = 3'd5,
    VID_DATA = 3'd6
  } state_t;
  localparam state_t FRAME_START = CTRL_HDR;
`else
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VID_HDR  = 2'd1,
    VID_DATA = 2'd2
  } state_t;
  localparam state_t FRAME_START = VID_HDR;
`endif

  // FIFO of {sof, data}; pointers carry one extra wrap bit
  logic [12:0]      mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             wr_en;
  logic             rd_en;
  logic             head_sof;
  logic [11:0]      head_data;

  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign wr_en = pix_valid && !full;
  assign {head_sof, head_data} = mem[rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge clk_clk) begin
    if (wr_en) begin
      mem[wr_ptr[FIFO_AW-1:0]] <= {pix_sof, pix_data};
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (pix_valid && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Output beat register can take a new beat when empty or being consumed
  state_t      state_q;
  state_t      state_d;
  logic        can_load;
  logic        load;
  logic [11:0] beat_data;
  logic        beat_sop;
  logic        beat_eop;
  logic        beat_done;
  logic        done_q;
  logic        cnt_clr;
  logic        cnt_inc;
  logic [31:0] pix_cnt;

  assign can_load = !dout_valid || dout_ready;

  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    load      = 1'b0;
    beat_data = 12'h000;
    beat_sop  = 1'b0;
    beat_eop  = 1'b0;
    beat_done = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          if (head_sof) begin
            state_d = FRAME_START;
          end else begin
            rd_en = 1'b1;
          end
        end
      end
`ifdef PKTZ_CTRL_PACKET_EN
      CTRL_HDR: begin
        if (can_load) begin
          load      = 1'b1;
          beat_data = 12'h00F;
          beat_sop  = 1'b1;
          state_d   = CTRL_B1;
        end
      end
      CTRL_B1: begin
        if (can_load) begin
          load      = 1'b1;
          beat_data = {W16[7:4], W16[11:8], W16[15:12]};
          state_d   = CTRL_B2;
        end
      end
      CTRL_B2: begin
        if (can_load) begin
          load      = 1'b1;
          beat_data = {H16[11:8], H16[15:12], W16[3:0]};
          state_d   = CTRL_B3;
        end
      end
      CTRL_B3: begin
        if (can_load) begin
          load      = 1'b1;
          beat_data = {4'h3, H16[3:0], H16[7:4]};
          beat_eop  = 1'b1;
          state_d   = VID_HDR;
        end
      end
`endif
      VID_HDR: begin
        if (can_load) begin
          load     = 1'b1;
          beat_sop = 1'b1;
          cnt_clr  = 1'b1;
          state_d  = VID_DATA;
        end
      end
      VID_DATA: begin
        if (can_load && !empty) begin
          load = 1'b1;
          if (head_sof && (pix_cnt != 32'd0)) begin
            // short frame: close with a filler beat, leave the sof pixel queued
            beat_eop = 1'b1;
            state_d  = FRAME_START;
          end else begin
            rd_en     = 1'b1;
            cnt_inc   = 1'b1;
            beat_data = head_data;
            if (pix_cnt == LAST_IDX) begin
              beat_eop  = 1'b1;
              beat_done = 1'b1;
              state_d   = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pix_cnt <= 32'd0;
    end else if (cnt_clr) begin
      pix_cnt <= 32'd0;
    end else if (cnt_inc) begin
      pix_cnt <= pix_cnt + 32'd1;
    end
  end

  // done_q travels with the beat so frame_count moves only on its transfer
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      dout_valid         <= 1'b0;
      dout_data          <= 12'h000;
      dout_startofpacket <= 1'b0;
      dout_endofpacket   <= 1'b0;
      done_q             <= 1'b0;
      frame_count        <= 16'd0;
    end else begin
      if (load) begin
        dout_valid         <= 1'b1;
        dout_data          <= beat_data;
        dout_startofpacket <= beat_sop;
        dout_endofpacket   <= beat_eop;
        done_q             <= beat_done;
      end else if (can_load) begin
        dout_valid         <= 1'b0;
        dout_startofpacket <= 1'b0;
        dout_endofpacket   <= 1'b0;
        done_q             <= 1'b0;
      end
      if (dout_valid && dout_ready && done_q) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vip_stream_packetizer.sv
// Self-checking bench for vip_stream_packetizer (FRAME_W=4, FRAME_H=2, FIFO_AW=4).
`default_nettype none

module tb_vip_stream_packetizer;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int NPIX = W * H;
`ifdef PKTZ_CTRL_PACKET_EN
  localparam bit CTRL_EN = 1'b1;
`else
  localparam bit CTRL_EN = 1'b0;
`endif

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [11:0] pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        pix_sof = 1'b0;
  logic [11:0] dout_data;
  logic        dout_valid;
  logic        dout_startofpacket;
  logic        dout_endofpacket;
  logic        dout_ready = 1'b1;
  logic        overflow;
  logic [15:0] frame_count;

  vip_stream_packetizer #(.FRAME_W(W), .FRAME_H(H), .FIFO_AW(4)) dut (
    .clk_clk            (clk_clk),
    .reset_reset_n      (reset_reset_n),
    .pix_data           (pix_data),
    .pix_valid          (pix_valid),
    .pix_sof            (pix_sof),
    .dout_data          (dout_data),
    .dout_valid         (dout_valid),
    .dout_startofpacket (dout_startofpacket),
    .dout_endofpacket   (dout_endofpacket),
    .dout_ready         (dout_ready),
    .overflow           (overflow),
    .frame_count        (frame_count)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    logic [11:0] data;
    logic        sop;
    logic        eop;
    logic [15:0] fc;
    int          idx;
  } beat_t;

  typedef struct {
    logic        in_valid;
    logic [11:0] in_data;
    logic        in_sof;
    logic [11:0] exp_data;
    logic        exp_sop;
    logic        exp_eop;
    logic        ctrl;
  } vec_t;

  beat_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          ready_mode = 0;   // 0 high, 1 toggle, 2 random, 3 low
  int          sent = 0;
  int          last_emitted = -1;
  bit          m_in_frame = 0;
  int          m_cnt = 0;
  logic [15:0] m_frames = 16'd0;
  bit          stall_prev = 0;
  logic [11:0] st_data;
  logic        st_sop;
  logic        st_eop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [11:0] d, input logic sop, input logic eop, input int idx);
    beat_t b;
    b.data = d; b.sop = sop; b.eop = eop; b.fc = m_frames; b.idx = idx;
    exp_q.push_back(b);
  endtask

  function automatic int nib(input int v, input int k);
    return (v >> (4 * k)) & 15;
  endfunction

  task automatic push_headers();
    if (CTRL_EN) begin
      push(12'h00F, 1'b1, 1'b0, -1);
      push(12'((nib(W, 1) << 8) | (nib(W, 2) << 4) | nib(W, 3)), 1'b0, 1'b0, -1);
      push(12'((nib(H, 2) << 8) | (nib(H, 3) << 4) | nib(W, 0)), 1'b0, 1'b0, -1);
      push(12'((3 << 8) | (nib(H, 0) << 4) | nib(H, 1)), 1'b0, 1'b1, -1);
    end
    push(12'h000, 1'b1, 1'b0, -1);
  endtask

  // Reference: what the sink must see for each pixel that enters the FIFO
  task automatic model_px(input logic [11:0] d, input logic s);
    int idx;
    idx = sent;
    sent++;
    if (m_in_frame && s) begin
      push(12'h000, 1'b0, 1'b1, -1);
      m_in_frame = 0;
    end
    if (!m_in_frame) begin
      if (!s) return;
      push_headers();
      m_in_frame = 1;
      m_cnt = 0;
    end
    m_cnt++;
    push(d, 1'b0, m_cnt == NPIX, idx);
    if (m_cnt == NPIX) begin
      m_in_frame = 0;
      m_frames = m_frames + 16'd1;
    end
  endtask

  task automatic monitor();
    beat_t e;
    if (!reset_reset_n) begin
      stall_prev = 0;
      return;
    end
    if (stall_prev)
      chk("stall_hold", {dout_valid, dout_data, dout_startofpacket, dout_endofpacket},
          {1'b1, st_data, st_sop, st_eop});
    if (dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_beat actual=%h required=none at %0t", dout_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("beat", {dout_data, dout_startofpacket, dout_endofpacket, frame_count},
            {e.data, e.sop, e.eop, e.fc});
        if (e.idx >= 0) last_emitted = e.idx;
      end
    end
    stall_prev = dout_valid && !dout_ready;
    st_data = dout_data;
    st_sop  = dout_startofpacket;
    st_eop  = dout_endofpacket;
  endtask

  task automatic tick();
    case (ready_mode)
      0: dout_ready = 1'b1;
      1: dout_ready = ~dout_ready;
      2: dout_ready = ($urandom_range(0, 3) != 0);
      default: dout_ready = 1'b0;
    endcase
    @(negedge clk_clk);
    monitor();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic send_px(input logic [11:0] d, input logic s, input bit use_model);
    pix_data = d;
    pix_sof = s;
    pix_valid = 1'b1;
    if (use_model) model_px(d, s);
    tick();
    pix_valid = 1'b0;
    pix_sof = 1'b0;
  endtask

  task automatic rnd_px(input logic s);
    int gap;
    int n;
    gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) tick();
    n = 0;
    while ((sent - (last_emitted + 1)) >= 10 && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL throttle_timeout actual=%0d required=<10", sent - (last_emitted + 1));
    end
    send_px(12'($urandom), s, 1'b1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout actual=%0d required=0 beats left", name, exp_q.size());
      exp_q.delete();
    end
    tick();
    tick();
    chk({name, "_frame_count"}, 32'(frame_count), 32'(m_frames));
  endtask

  initial begin
    vec_t vec[13];
    vec[0]  = '{1'b1, 12'h001, 1'b1, 12'h00F, 1'b1, 1'b0, 1'b1};
    vec[1]  = '{1'b1, 12'h002, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1};
    vec[2]  = '{1'b1, 12'h003, 1'b0, 12'h004, 1'b0, 1'b0, 1'b1};
    vec[3]  = '{1'b1, 12'h004, 1'b0, 12'h320, 1'b0, 1'b1, 1'b1};
    vec[4]  = '{1'b1, 12'h005, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0};
    vec[5]  = '{1'b1, 12'h006, 1'b0, 12'h001, 1'b0, 1'b0, 1'b0};
    vec[6]  = '{1'b1, 12'h007, 1'b0, 12'h002, 1'b0, 1'b0, 1'b0};
    vec[7]  = '{1'b1, 12'h008, 1'b0, 12'h003, 1'b0, 1'b0, 1'b0};
    vec[8]  = '{1'b0, 12'h000, 1'b0, 12'h004, 1'b0, 1'b0, 1'b0};
    vec[9]  = '{1'b0, 12'h000, 1'b0, 12'h005, 1'b0, 1'b0, 1'b0};
    vec[10] = '{1'b0, 12'h000, 1'b0, 12'h006, 1'b0, 1'b0, 1'b0};
    vec[11] = '{1'b0, 12'h000, 1'b0, 12'h007, 1'b0, 1'b0, 1'b0};
    vec[12] = '{1'b0, 12'h000, 1'b0, 12'h008, 1'b0, 1'b1, 1'b0};

    repeat (3) @(posedge clk_clk);
    #1;
    chk("reset_state", {dout_valid, dout_data, dout_startofpacket, dout_endofpacket, overflow, frame_count},
        32'd0);
    reset_reset_n = 1'b1;
    tick();

    // Directed frame from the table, sink always ready
    ready_mode = 0;
    for (int i = 0; i < 13; i++) begin
      if (vec[i].ctrl && !CTRL_EN) continue;
      push(vec[i].exp_data, vec[i].exp_sop, vec[i].exp_eop, -1);
    end
    for (int i = 0; i < 13; i++)
      if (vec[i].in_valid) send_px(vec[i].in_data, vec[i].in_sof, 1'b0);
    sent += NPIX;
    m_frames = m_frames + 16'd1;
    drain("table_frame");
    last_emitted = sent - 1;

    // Same frame, ready toggling every cycle
    ready_mode = 1;
    for (int i = 0; i < NPIX; i++) send_px(12'(i + 1), i == 0, 1'b1);
    drain("toggle_frame");

    // Leading pixels without sof are discarded
    ready_mode = 0;
    for (int i = 0; i < 3; i++) send_px(12'hA00 + 12'(i), 1'b0, 1'b1);
    for (int i = 0; i < NPIX; i++) send_px(12'(i + 1), i == 0, 1'b1);
    drain("garbage_frame");

    // Short frame of 5 followed by a full frame
    for (int i = 0; i < 5; i++) send_px(12'h500 + 12'(i), i == 0, 1'b1);
    for (int i = 0; i < NPIX; i++) send_px(12'h600 + 12'(i), i == 0, 1'b1);
    drain("short_frame");

    // Random frames (full, short, long, with garbage) under random backpressure
    ready_mode = 2;
    for (int f = 0; f < 14; f++) begin
      int kind;
      int n;
      int extra;
      kind = (f == 13) ? 0 : int'($urandom_range(0, 3));
      n = NPIX;
      extra = 0;
      if (kind == 1) n = $urandom_range(1, NPIX - 1);
      if (kind == 2) extra = $urandom_range(1, 3);
      if (kind == 3) for (int g = 0; g < 3; g++) rnd_px(1'b0);
      for (int p = 0; p < n + extra; p++) rnd_px(p == 0);
    end
    drain("random");
    chk("no_overflow_random", 32'(overflow), 32'd0);

    // Overflow: sink stalled, 20 back-to-back pixels, 16 kept
    ready_mode = 3;
    for (int i = 1; i <= 20; i++) begin
      send_px(12'h700 + 12'(i), (i == 1) || (i == 9), i <= 16);
      chk($sformatf("overflow_px%0d", i), 32'(overflow), 32'(i >= 17));
    end
    ready_mode = 0;
    drain("overflow");
    chk("overflow_sticky", 32'(overflow), 32'd1);

    // Asynchronous reset in the middle of a video packet
    for (int i = 0; i < 3; i++) send_px(12'hB00 + 12'(i + 1), i == 0, 1'b1);
    drain("pre_reset");
    ready_mode = 3;
    send_px(12'hB04, 1'b0, 1'b1);
    repeat (3) tick();
    chk("stall_before_reset", 32'(dout_valid), 32'd1);
    reset_reset_n = 1'b0;
    #1;
    chk("async_reset_outs", {dout_valid, dout_data, dout_startofpacket, dout_endofpacket, overflow, frame_count},
        32'd0);
    exp_q.delete();
    m_in_frame = 0;
    m_cnt = 0;
    m_frames = 16'd0;
    tick();
    tick();
    reset_reset_n = 1'b1;
    last_emitted = sent - 1;
    ready_mode = 0;
    for (int i = 0; i < NPIX; i++) send_px(12'hC00 + 12'(i), i == 0, 1'b1);
    drain("post_reset");
    chk("post_reset_overflow", 32'(overflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
